// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Serial line idles high; bytes go out LSB first; back-to-back frames have no gap.
// Optional build macro UART_TX_PARITY_EN inserts a parity bit between the data
// bits and the stop bit (even when PARITY_ODD=0, odd when PARITY_ODD=1).
//
// state    | meaning
// S_IDLE   | line high, waiting for a queued byte
// S_START  | start bit (low)
// S_DATA   | eight data bits, LSB first
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (high); pops the next byte straight into S_START
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  // Reject parameter sets the counters and pointer wrap cannot support.
  if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_tx: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  state_t          state_q;
  logic [CNTW-1:0] clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            serial_q;
  logic            active_q;
  logic            done_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic            bit_last;
  logic            fifo_nonempty;
  logic            push;
  logic            pop;
  logic [7:0]      head;

  assign bit_last      = (clk_cnt_q == CNT_LAST);
  assign fifo_nonempty = (count_q != '0);
  // Ready comes from the registered count, so a full FIFO refuses a write even
  // if the shifter pops on the same edge.
  assign push          = i_Tx_DV && (count_q != DEPTH_C);
  assign pop           = fifo_nonempty &&
                         ((state_q == S_IDLE) || (state_q == S_STOP && bit_last));
  assign head          = mem_q[rd_ptr_q];

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Frame sequencer with registered line, active and done outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          if (pop) begin
            shift_q  <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^head) ^ (PARITY_ODD != 0);
`endif
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              serial_q <= parity_q;
              state_q  <= S_PARITY;
`else
              serial_q <= 1'b1;
              state_q  <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            serial_q  <= 1'b1;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            done_q    <= 1'b1;
            if (pop) begin
              shift_q  <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= (^head) ^ (PARITY_ODD != 0);
`endif
              serial_q <= 1'b0;
              state_q  <= S_START;
            end else begin
              serial_q <= 1'b1;
              active_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          clk_cnt_q <= '0;
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Tx_Ready   = (count_q != DEPTH_C);
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected frames are hand-written bit vectors, bit i = i-th bit on the line.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic [2:0] fifo_count;

  int n_chk;
  int n_pass;
  int done_cnt;
  int base;
  int bad;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Tx_DV      (tx_dv),
    .i_Tx_Byte    (tx_byte),
    .o_Tx_Ready   (tx_ready),
    .o_Tx_Serial  (tx_serial),
    .o_Tx_Active  (tx_active),
    .o_Tx_Done    (tx_done),
    .o_Fifo_Count (fifo_count)
  );

`ifdef UART_TX_PARITY_EN
  logic       so_ready;
  logic       so_serial;
  logic       so_active;
  logic       so_done;
  logic [2:0] so_count;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_ODD(1)) u_dut_odd (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Tx_DV      (tx_dv),
    .i_Tx_Byte    (tx_byte),
    .o_Tx_Ready   (so_ready),
    .o_Tx_Serial  (so_serial),
    .o_Tx_Active  (so_active),
    .o_Tx_Done    (so_done),
    .o_Fifo_Count (so_count)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one frame sample by sample starting at frame cycle 'first'.
  task automatic check_frame(input string tag, input logic [10:0] exp, input int nbits,
                             input int first);
    for (int i = first; i < nbits * CPB; i++) begin
      chk(tag, {31'd0, tx_serial}, {31'd0, exp[i / CPB]});
      if (i % CPB == 0) chk({tag, "_active"}, {31'd0, tx_active}, 32'd1);
      tick();
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    tx_dv    = 1'b0;
    tx_byte  = 8'h00;

    #12;
    chk("rst_serial", {31'd0, tx_serial}, 32'd1);
    chk("rst_active", {31'd0, tx_active}, 32'd0);
    chk("rst_done",   {31'd0, tx_done},   32'd0);
    chk("rst_count",  {29'd0, fifo_count}, 32'd0);
    chk("rst_ready",  {31'd0, tx_ready},  32'd1);
    #6 rst_n = 1'b1;
    tick();

    // Idle line with no writes.
    bad = 0;
    repeat (1000) begin
      tick();
      if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("idle_line", bad, 0);
    chk("idle_done_cnt", done_cnt, 0);

`ifndef UART_TX_PARITY_EN
    // Single byte 0x37.
    tx_dv = 1'b1; tx_byte = 8'h37;
    tick();
    tx_dv = 1'b0;
    chk("lat_count", {29'd0, fifo_count}, 32'd1);
    chk("lat_serial_high", {31'd0, tx_serial}, 32'd1);
    tick();
    chk("start_count", {29'd0, fifo_count}, 32'd0);
    check_frame("f37", 11'h26E, 10, 0);
    chk("f37_done",   {31'd0, tx_done},   32'd1);
    chk("f37_active", {31'd0, tx_active}, 32'd0);
    chk("f37_line",   {31'd0, tx_serial}, 32'd1);
    tick();
    chk("f37_done_off", {31'd0, tx_done}, 32'd0);
    chk("f37_done_cnt", done_cnt, 1);

    // Three back-to-back frames.
    base = done_cnt;
    tx_dv = 1'b1; tx_byte = 8'hA5;
    tick();
    chk("b2b_cnt1", {29'd0, fifo_count}, 32'd1);
    tx_byte = 8'h0F;
    tick();
    chk("b2b_cnt2", {29'd0, fifo_count}, 32'd1);
    chk("b2b_start", {31'd0, tx_serial}, 32'd0);
    tx_byte = 8'hFF;
    tick();
    chk("b2b_cnt3", {29'd0, fifo_count}, 32'd2);
    tx_dv = 1'b0;
    check_frame("fa5", 11'h34A, 10, 1);
    chk("b2b_done_a5", {31'd0, tx_done}, 32'd1);
    chk("b2b_cnt_a5", {29'd0, fifo_count}, 32'd1);
    check_frame("f0f", 11'h21E, 10, 0);
    chk("b2b_cnt_0f", {29'd0, fifo_count}, 32'd0);
    check_frame("fff", 11'h3FE, 10, 0);
    chk("b2b_active_end", {31'd0, tx_active}, 32'd0);
    tick();
    chk("b2b_done_cnt", done_cnt - base, 3);

    // Overfill during a long frame: six writes, four accepted.
    base = done_cnt;
    tx_dv = 1'b1; tx_byte = 8'h55;
    tick();
    tx_dv = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tx_dv = 1'b1; tx_byte = 8'(k);
      tick();
      if (k == 4) begin
        chk("full_cnt", {29'd0, fifo_count}, 32'd4);
        chk("full_ready", {31'd0, tx_ready}, 32'd0);
      end
    end
    tx_dv = 1'b0;
    chk("full_cnt_after", {29'd0, fifo_count}, 32'd4);
    chk("full_ready_after", {31'd0, tx_ready}, 32'd0);
    check_frame("f55", 11'h2AA, 10, 6);
    chk("full_cnt_q3", {29'd0, fifo_count}, 32'd3);
    check_frame("f01", 11'h202, 10, 0);
    check_frame("f02", 11'h204, 10, 0);
    check_frame("f03", 11'h206, 10, 0);
    check_frame("f04", 11'h208, 10, 0);
    chk("full_active_end", {31'd0, tx_active}, 32'd0);
    chk("full_line_end", {31'd0, tx_serial}, 32'd1);
    tick();
    chk("full_done_cnt", done_cnt - base, 5);
    chk("full_cnt_end", {29'd0, fifo_count}, 32'd0);

    // Reset in data bit 3 of 0x55 with two bytes queued.
    tx_dv = 1'b1; tx_byte = 8'h55;
    tick();
    tx_dv = 1'b0;
    tick();
    tx_dv = 1'b1; tx_byte = 8'h11;
    tick();
    tx_byte = 8'h22;
    tick();
    tx_dv = 1'b0;
    chk("rmid_cnt", {29'd0, fifo_count}, 32'd2);
    repeat (15) tick();
    chk("rmid_bit3", {31'd0, tx_serial}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_serial", {31'd0, tx_serial}, 32'd1);
    chk("rmid_active", {31'd0, tx_active}, 32'd0);
    chk("rmid_count",  {29'd0, fifo_count}, 32'd0);
    chk("rmid_ready",  {31'd0, tx_ready},  32'd1);
    base = done_cnt;
    #8 rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (tx_serial !== 1'b1 || tx_active !== 1'b0) bad++;
    end
    chk("rpost_line", bad, 0);
    chk("rpost_done", done_cnt - base, 0);
    chk("rpost_count", {29'd0, fifo_count}, 32'd0);
`else
    // 0x07 with parity: even instance sends 1, odd instance sends 0.
    tx_dv = 1'b1; tx_byte = 8'h07;
    tick();
    tx_dv = 1'b0;
    tick();
    begin
      logic [10:0] exp_e;
      logic [10:0] exp_o;
      exp_e = 11'h60E;
      exp_o = 11'h40E;
      for (int i = 0; i < 11 * CPB; i++) begin
        chk("par_even", {31'd0, tx_serial}, {31'd0, exp_e[i / CPB]});
        chk("par_odd",  {31'd0, so_serial}, {31'd0, exp_o[i / CPB]});
        tick();
      end
    end
    chk("par_even_done", {31'd0, tx_done}, 32'd1);
    chk("par_odd_done",  {31'd0, so_done}, 32'd1);
    chk("par_even_active", {31'd0, tx_active}, 32'd0);
    tick();
    chk("par_done_cnt", done_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
